// File: rtl/bcd_to_binary_seq_if.sv
// Handshake and data bundle for the sequential BCD-to-binary converter.
// The master side requests a conversion. The slave side (the converter) answers with busy/done/err/bin.
interface bcd_to_binary_seq_if #(
  parameter int NDIGITS = 3,
  parameter int BIN_W   = 10
);
  logic                 start;
  logic [4*NDIGITS-1:0] bcd_in;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [BIN_W-1:0]     bin;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  err,
    input  bin
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output err,
    output bin
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Each SHIFT cycle shifts {bcd_r, bin_r} right by one bit.
// In the same step, every BCD digit that reads >= 8 has 3 subtracted.
// After BIN_W steps, bin_r holds the binary value and bcd_r is all zero.
// A digit > 9 at accept time skips the shifting and reports err with done one cycle later.
module bcd_to_binary_seq #(
  parameter int NDIGITS = 3,
  parameter int BIN_W   = 10
) (
  input  logic clk,
  input  logic rst_n,
  bcd_to_binary_seq_if.slave bus
);

  localparam int BCD_W = 4 * NDIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [BCD_W-1:0]   bcd_r;
  logic [BIN_W-1:0]   bin_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               err_r;
  logic               busy_r;
  logic               done_r;

  logic [BCD_W+BIN_W-1:0] shift_s;
  logic [BCD_W-1:0]       bcd_next_s;
  logic [BIN_W-1:0]       bin_next_s;

  // True when any 4-bit digit of the word is outside 0..9.
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // Reverse double-dabble correction: digits reading >= 8 after the shift lose 3.
  function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd8) begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // One shift-and-correct step, computed ahead of the registers.
  always_comb begin
    shift_s    = {bcd_r, bin_r} >> 1;
    bcd_next_s = correct_digits(shift_s[BCD_W+BIN_W-1 -: BCD_W]);
    bin_next_s = shift_s[BIN_W-1:0];
  end

  // Control FSM and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      bcd_r   <= '0;
      bin_r   <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          if (bus.start) begin
            if (has_bad_digit(bus.bcd_in)) begin
              // Invalid digits: report immediately without shifting.
              err_r   <= 1'b1;
              bin_r   <= '0;
              bcd_r   <= '0;
              cnt_r   <= '0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              err_r   <= 1'b0;
              bin_r   <= '0;
              bcd_r   <= bus.bcd_in;
              cnt_r   <= '0;
              busy_r  <= 1'b1;
              state_r <= ST_SHIFT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          bcd_r <= bcd_next_s;
          bin_r <= bin_next_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_STEP) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;
  assign bus.bin  = bin_r;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed scenarios plus randomized jobs
// compared against an arithmetic reference (digit-weighted sum, err on any digit > 9).
module tb_bcd_to_binary_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  bcd_to_binary_seq_if #(.NDIGITS(3), .BIN_W(10)) bif ();

  bcd_to_binary_seq #(.NDIGITS(3), .BIN_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain decimal arithmetic on the three digits.
  function automatic void ref_conv(input logic [11:0] b, output logic e, output logic [9:0] v, output int lat);
    int d0, d1, d2;
    d0 = int'(b[3:0]);
    d1 = int'(b[7:4]);
    d2 = int'(b[11:8]);
    e  = (d0 > 9) || (d1 > 9) || (d2 > 9);
    v  = e ? 10'd0 : 10'(d2 * 100 + d1 * 10 + d0);
    lat = e ? 1 : 11;
  endfunction

  // Raise start for one edge with data b; returns right after the accepting edge (+1).
  task automatic launch(input logic [11:0] b);
    bif.start  = 1'b1;
    bif.bcd_in = b;
    @(posedge clk); #1;
    bif.start  = 1'b0;
    bif.bcd_in = 12'($urandom);
  endtask

  // Wait (bounded) for done; cyc = cycle index of done after accept, bc = busy cycles seen.
  task automatic wait_done(output int cyc, output int bc);
    cyc = 1;
    bc  = 0;
    while (bif.done !== 1'b1 && cyc < 30) begin
      if (bif.busy === 1'b1) bc++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc, bc;
    rst_n = 1'b0;
    bif.start = 1'b0;
    bif.bcd_in = 12'h000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    launch(12'h999);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.err !== 1'b0 || bif.bin !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b done=%b err=%b bin=%0d, required all 0", bif.busy, bif.done, bif.err, bif.bin);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", bif.busy, bif.done);
    end
  endtask

  task automatic test_valid_255();
    int cyc, bc;
    launch(12'h255);
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== 11 || bc !== 10) begin
      n_fail++;
      $display("FAIL valid_255_timing: done cycle=%0d busy cycles=%0d, required 11 10", cyc, bc);
    end
    n_cmp++;
    if (bif.bin !== 10'd255 || bif.err !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_255_value: bin=%0d err=%b, required 255 0", bif.bin, bif.err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bif.done !== 1'b0 || bif.bin !== 10'd255) begin
      n_fail++;
      $display("FAIL valid_255_pulse: done=%b bin=%0d, required 0 255 (held)", bif.done, bif.bin);
    end
  endtask

  task automatic test_bounds_invalid();
    logic [11:0] vec [5];
    logic e; logic [9:0] v; int lat; int cyc, bc;
    vec[0] = 12'h000; vec[1] = 12'h999; vec[2] = 12'h100; vec[3] = 12'h0A3; vec[4] = 12'h042;
    for (int i = 0; i < 5; i++) begin
      ref_conv(vec[i], e, v, lat);
      launch(vec[i]);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== lat || bif.bin !== v || bif.err !== e) begin
        n_fail++;
        $display("FAIL bounds_%03h: cycle=%0d bin=%0d err=%b, required %0d %0d %b", vec[i], cyc, bif.bin, bif.err, lat, v, e);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int cyc, bc;
    launch(12'h255);
    for (int k = 0; k < 4; k++) begin
      bif.start  = 1'b1;
      bif.bcd_in = 12'h9A9;
      @(posedge clk); #1;
      bif.start  = 1'b0;
      bif.bcd_in = 12'h888;
      @(posedge clk); #1;
    end
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== 3 || bif.bin !== 10'd255 || bif.err !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore: remaining cycle=%0d bin=%0d err=%b, required 3 255 0", cyc, bif.bin, bif.err);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    launch(12'h123);
    wait_done(cyc, bc);
    bif.start  = 1'b1;
    bif.bcd_in = 12'h456;
    @(posedge clk); #1;
    bif.start  = 1'b0;
    n_cmp++;
    if (bif.busy !== 1'b1 || bif.done !== 1'b0 || bif.bin !== 10'd0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b bin=%0d, required 1 0 0", bif.busy, bif.done, bif.bin);
    end
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== 11 || bif.bin !== 10'd456) begin
      n_fail++;
      $display("FAIL b2b_result: cycle=%0d bin=%0d, required 11 456", cyc, bif.bin);
    end
  endtask

  task automatic test_reset_midop();
    int cyc, bc, seen;
    launch(12'h777);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bif.busy !== 1'b0 || bif.bin !== 10'd0) begin
      n_fail++;
      $display("FAIL midop_reset: busy=%b bin=%0d, required 0 0", bif.busy, bif.bin);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (bif.done === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midop_no_done: done pulses=%0d, required 0", seen);
    end
    launch(12'h321);
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== 11 || bif.bin !== 10'd321) begin
      n_fail++;
      $display("FAIL midop_restart: cycle=%0d bin=%0d, required 11 321", cyc, bif.bin);
    end
  endtask

  task automatic test_random();
    logic [11:0] b; logic e; logic [9:0] v; int lat; int cyc, bc;
    for (int i = 0; i < 60; i++) begin
      for (int d = 0; d < 3; d++) begin
        b[4*d +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      ref_conv(b, e, v, lat);
      launch(b);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== lat || bif.bin !== v || bif.err !== e) begin
        n_fail++;
        $display("FAIL random_%03h: cycle=%0d bin=%0d err=%b, required %0d %0d %b", b, cyc, bif.bin, bif.err, lat, v, e);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  task automatic test_roundtrip();
    logic [11:0] b; int cyc, bc;
    for (int n = 0; n < 256; n++) begin
      b = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
      launch(b);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== 11 || bif.err !== 1'b0 || bif.bin !== 10'(n)) begin
        n_fail++;
        $display("FAIL roundtrip_%0d: cycle=%0d bin=%0d err=%b, required 11 %0d 0", n, cyc, bif.bin, bif.err, n);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bif.start  = 1'b0;
    bif.bcd_in = 12'h000;
    test_reset();
    test_valid_255();
    test_bounds_invalid();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    test_random();
    test_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
